mod_settings_scheduler: RTL and testbench

MOD_SETTINGS_SCHEDULER -- requirements
Module: mod_settings_scheduler

---
 rtl/mod_settings_scheduler_if.sv | 25 ++
 rtl/mod_settings_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_mod_settings_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_settings_scheduler_if.sv
// Host request/response bus for the settings scheduler.
interface mod_settings_scheduler_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_segment;
  logic [14:0] req_cycle;
  logic [15:0] req_rep;
  logic        req_switch;
  logic [7:0]  req_transition_mode;
  logic [63:0] req_transition_value;
  logic        resp_valid;
  logic [1:0]  resp_err;

  modport master (
    output req_valid, req_segment, req_cycle, req_rep, req_switch,
           req_transition_mode, req_transition_value,
    input  req_ready, resp_valid, resp_err
  );

  modport slave (
    input  req_valid, req_segment, req_cycle, req_rep, req_switch,
           req_transition_mode, req_transition_value,
    output req_ready, resp_valid, resp_err
  );
endinterface

// File: rtl/mod_settings_scheduler.sv
// Settings scheduler: validates a host request, writes the per-segment
// CYCLE/REP registers and, for switch requests, issues a delayed
// UPDATE_SETTINGS pulse to the swapchain while tracking a pending
// finite transition.
module mod_settings_scheduler #(
  parameter int unsigned SettleCycles = 2,
  parameter logic [7:0]  ModeExt      = 8'd3,
  parameter logic [7:0]  ModeGpio     = 8'd4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  mod_settings_scheduler_if.slave  req_if,
  input  logic                     abort_i,
  input  logic                     segment_i,
  input  logic                     stop_i,
  output logic [14:0]              cycle_o [2],
  output logic [15:0]              rep_o [2],
  output logic                     update_settings_o,
  output logic                     req_rd_segment_o,
  output logic [7:0]               transition_mode_o,
  output logic [63:0]              transition_value_o,
  output logic                     pending_o
);

  localparam int unsigned NumSegment = 2;
  localparam logic [2:0]  SettleLast = 3'(SettleCycles - 1);

  typedef enum logic [1:0] {StIdle, StCheck, StSettle, StFire} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  // Request capture registers
  logic        seg_q;
  logic [14:0] cyc_req_q;
  logic [15:0] rep_req_q;
  logic        sw_q;
  logic [7:0]  mode_q;
  logic [63:0] value_q;

  logic [14:0] cycle_q [NumSegment];
  logic [15:0] rep_q [NumSegment];
  logic        rd_seg_q;
  logic [7:0]  tmode_q;
  logic [63:0] tvalue_q;
  logic        pending_q, pending_d;

  logic        ready;
  logic        accept;
  logic        resp_valid;
  logic [1:0]  resp_err;
  logic        update;
  logic        write_en;
  logic        latch_en;
  logic [1:0]  err_code;

  assign accept = req_if.req_valid && ready;

  // Error classification of the captured request, highest code wins.
  always_comb begin
    err_code = 2'd0;
    if ((sw_q && rep_req_q != 16'hFFFF && mode_q == ModeExt) ||
        (mode_q == ModeGpio && value_q > 64'd3)) begin
      err_code = 2'd3;
    end else if (sw_q && pending_q) begin
      err_code = 2'd2;
    end else if (seg_q == segment_i && !stop_i) begin
      err_code = 2'd1;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready      = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 2'd0;
    update     = 1'b0;
    write_en   = 1'b0;
    latch_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (req_if.req_valid) state_d = StCheck;
      end
      StCheck: begin
        if (err_code != 2'd0) begin
          resp_valid = 1'b1;
          resp_err   = err_code;
          state_d    = StIdle;
        end else begin
          write_en = 1'b1;
          if (!sw_q) begin
            resp_valid = 1'b1;
            state_d    = StIdle;
          end else begin
            latch_en = 1'b1;
            cnt_d    = 3'd0;
            state_d  = StSettle;
          end
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StFire;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StFire: begin
        update     = 1'b1;
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and settle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture all request fields on the handshake only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_q     <= 1'b0;
      cyc_req_q <= '0;
      rep_req_q <= '0;
      sw_q      <= 1'b0;
      mode_q    <= '0;
      value_q   <= '0;
    end else if (accept) begin
      seg_q     <= req_if.req_segment;
      cyc_req_q <= req_if.req_cycle;
      rep_req_q <= req_if.req_rep;
      sw_q      <= req_if.req_switch;
      mode_q    <= req_if.req_transition_mode;
      value_q   <= req_if.req_transition_value;
    end
  end

  // Per-segment CYCLE/REP registers, written once a request checks OK.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumSegment; i++) begin
        cycle_q[i] <= '0;
        rep_q[i]   <= 16'hFFFF;
      end
    end else if (write_en) begin
      cycle_q[seg_q] <= cyc_req_q;
      rep_q[seg_q]   <= rep_req_q;
    end
  end

  // Transition settings and target segment handed to the swapchain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_seg_q <= 1'b0;
      tmode_q  <= '0;
      tvalue_q <= '0;
    end else if (latch_en) begin
      rd_seg_q <= seg_q;
      tmode_q  <= mode_q;
      tvalue_q <= value_q;
    end
  end

  // Pending: set by FIRE for finite loops (beats ABORT), cleared by ABORT
  // or once the swapchain runs the target segment.
  always_comb begin
    pending_d = pending_q;
    if (state_q == StFire) begin
      pending_d = (rep_req_q != 16'hFFFF);
    end else if (abort_i) begin
      pending_d = 1'b0;
    end else if (pending_q && segment_i == rd_seg_q && !stop_i) begin
      pending_d = 1'b0;
    end
  end

  // Pending flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign req_if.req_ready  = ready;
  assign req_if.resp_valid = resp_valid;
  assign req_if.resp_err   = resp_err;

  assign cycle_o            = cycle_q;
  assign rep_o              = rep_q;
  assign update_settings_o  = update;
  assign req_rd_segment_o   = rd_seg_q;
  assign transition_mode_o  = tmode_q;
  assign transition_value_o = tvalue_q;
  assign pending_o          = pending_q;

endmodule

// File: tb/tb_mod_settings_scheduler.sv
// Bench for mod_settings_scheduler: table of requests with a scoreboard of
// expected responses, plus hand sequences for pending clear, ABORT/FIRE
// collision and reset during SETTLE.
module tb_mod_settings_scheduler;

  localparam int unsigned Settle = 2;
  localparam logic [7:0] MSync = 8'd1;
  localparam logic [7:0] MSys  = 8'd2;
  localparam logic [7:0] MExt  = 8'd3;
  localparam logic [7:0] MGpio = 8'd4;

  typedef struct {
    logic        abort_first;
    logic        seg_i;
    logic        stop_i;
    logic        seg;
    logic [14:0] cyc;
    logic [15:0] rep;
    logic        sw;
    logic [7:0]  mode;
    logic [63:0] val;
    logic [1:0]  err;
    logic        pend;
  } vec_t;

  typedef struct {
    logic [1:0] err;
    logic       upd;
    logic       rdseg;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        seg = 1'b0;
  logic        stop = 1'b0;
  logic [14:0] cyc_o [2];
  logic [15:0] rep_o [2];
  logic        upd_o;
  logic        rd_o;
  logic [7:0]  tm_o;
  logic [63:0] tv_o;
  logic        pend_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int resp_cnt = 0;
  logic upd_prev = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  logic [14:0] m_cyc [2];
  logic [15:0] m_rep [2];
  logic [7:0]  m_tm;
  logic [63:0] m_tv;

  vec_t vecs[13];

  mod_settings_scheduler_if bus ();

  mod_settings_scheduler #(
    .SettleCycles (Settle)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_if             (bus),
    .abort_i            (abort),
    .segment_i          (seg),
    .stop_i             (stop),
    .cycle_o            (cyc_o),
    .rep_o              (rep_o),
    .update_settings_o  (upd_o),
    .req_rd_segment_o   (rd_o),
    .transition_mode_o  (tm_o),
    .transition_value_o (tv_o),
    .pending_o          (pend_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every RESP_VALID.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_update", upd_o, 1'b0);
      upd_prev = 1'b0;
    end else begin
      if (upd_prev) check("upd_consecutive", upd_o, 1'b0);
      upd_prev = upd_o;
      if (bus.resp_valid) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          check("spurious_resp", bus.resp_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_err", bus.resp_err, mon_e.err);
          check("resp_cycle", cyc, mon_e.cyc);
          check("resp_update", upd_o, mon_e.upd);
          if (mon_e.upd) check("rd_segment", rd_o, mon_e.rdseg);
        end
      end else if (upd_o) begin
        check("update_without_resp", upd_o, 1'b0);
      end
    end
  end

  task automatic model_reset();
    m_cyc[0] = '0;
    m_cyc[1] = '0;
    m_rep[0] = 16'hFFFF;
    m_rep[1] = 16'hFFFF;
    m_tm     = '0;
    m_tv     = '0;
  endtask

  // Drive one request through the handshake; returns at the cycle-1 negedge.
  task automatic drive_req(input vec_t v, input string tag);
    exp_t e;
    seg  = v.seg_i;
    stop = v.stop_i;
    if (v.abort_first) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
    end
    check({tag, "_ready"}, bus.req_ready, 1'b1);
    bus.req_valid            = 1'b1;
    bus.req_segment          = v.seg;
    bus.req_cycle            = v.cyc;
    bus.req_rep              = v.rep;
    bus.req_switch           = v.sw;
    bus.req_transition_mode  = v.mode;
    bus.req_transition_value = v.val;
    e.err   = v.err;
    e.upd   = (v.err == 2'd0) && v.sw;
    e.rdseg = v.seg;
    e.cyc   = cyc + ((e.upd) ? (2 + int'(Settle)) : 1);
    sb.push_back(e);
    if (v.err == 2'd0) begin
      m_cyc[v.seg] = v.cyc;
      m_rep[v.seg] = v.rep;
      if (v.sw) begin
        m_tm = v.mode;
        m_tv = v.val;
      end
    end
    @(negedge clk);
    // Junk on the bus outside the handshake must be ignored.
    bus.req_valid            = 1'b0;
    bus.req_segment          = 1'($urandom);
    bus.req_cycle            = 15'($urandom);
    bus.req_rep              = 16'($urandom);
    bus.req_switch           = 1'($urandom);
    bus.req_transition_mode  = 8'($urandom);
    bus.req_transition_value = {$urandom, $urandom};
  endtask

  task automatic finish_req(input vec_t v, input int base, input string tag);
    int waitc = 0;
    #1;
    while (resp_cnt == base && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    check({tag, "_resp_seen"}, resp_cnt != base, 1'b1);
    @(negedge clk);
    #1;
    check({tag, "_cycle0"}, cyc_o[0], m_cyc[0]);
    check({tag, "_cycle1"}, cyc_o[1], m_cyc[1]);
    check({tag, "_rep0"}, rep_o[0], m_rep[0]);
    check({tag, "_rep1"}, rep_o[1], m_rep[1]);
    check({tag, "_tmode"}, tm_o, m_tm);
    check({tag, "_tvalue"}, tv_o, m_tv);
    check({tag, "_pending"}, pend_o, v.pend);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int base;
    base = resp_cnt;
    drive_req(v, tag);
    finish_req(v, base, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   base;

    //            ab   sgi   stp   seg   cyc     rep       sw    mode   val                    err    pend
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd99, 16'hFFFF, 1'b1, MSync, 64'h0123456789abcdef, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 15'd5,  16'd7,    1'b0, MSync, 64'd0,                2'd1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 15'd5,  16'd7,    1'b0, MSync, 64'd0,                2'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd12, 16'd3,    1'b0, MSys,  64'd0,                2'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd20, 16'd3,    1'b1, MSys,  64'hffff000012345678, 2'd0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd30, 16'd5,    1'b1, MSync, 64'd0,                2'd2, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd31, 16'd5,    1'b1, MExt,  64'd0,                2'd3, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd32, 16'd6,    1'b0, MGpio, 64'd4,                2'd3, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd40, 16'd9,    1'b0, MGpio, 64'd3,                2'd0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 15'd41, 16'd5,    1'b1, MExt,  64'd0,                2'd3, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 15'd42, 16'd8,    1'b0, MGpio, 64'd9,                2'd3, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd50, 16'hFFFF, 1'b1, MExt,  64'd7,                2'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 15'd60, 16'hFFFF, 1'b1, MGpio, 64'd3,                2'd0, 1'b0};

    model_reset();
    bus.req_valid            = 1'b0;
    bus.req_segment          = 1'b0;
    bus.req_cycle            = '0;
    bus.req_rep              = '0;
    bus.req_switch           = 1'b0;
    bus.req_transition_mode  = '0;
    bus.req_transition_value = '0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_err", bus.resp_err, 2'd0);
    check("rst_pending", pend_o, 1'b0);
    check("rst_rdseg", rd_o, 1'b0);
    check("rst_tmode", tm_o, 8'd0);
    check("rst_tvalue", tv_o, 64'd0);
    check("rst_cycle0", cyc_o[0], 15'd0);
    check("rst_cycle1", cyc_o[1], 15'd0);
    check("rst_rep0", rep_o[0], 16'hFFFF);
    check("rst_rep1", rep_o[1], 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Pending clears once the swapchain runs the target segment.
    v = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd70, 16'd3, 1'b1, MSys, 64'd11, 2'd0, 1'b1};
    run_vec(v, "pclr");
    check("pclr_still_set", pend_o, 1'b1);
    seg = 1'b1;
    @(negedge clk);
    #1;
    check("pclr_cleared", pend_o, 1'b0);

    // ABORT during FIRE: FIRE wins.
    v = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd71, 16'd4, 1'b1, MSys, 64'd12, 2'd0, 1'b1};
    base = resp_cnt;
    drive_req(v, "abfire");
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abfire_resp", resp_cnt - base, 1);
    check("abfire_pending", pend_o, 1'b1);
    check("abfire_cycle1", cyc_o[1], m_cyc[1]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_clears", pend_o, 1'b0);

    // Reset while in SETTLE abandons the request.
    v = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd77, 16'hFFFF, 1'b1, MSync, 64'd99, 2'd0, 1'b0};
    drive_req(v, "rstmid");
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check("rstmid_ready", bus.req_ready, 1'b1);
    check("rstmid_resp", bus.resp_valid, 1'b0);
    check("rstmid_update", upd_o, 1'b0);
    check("rstmid_pending", pend_o, 1'b0);
    check("rstmid_rdseg", rd_o, 1'b0);
    check("rstmid_tmode", tm_o, 8'd0);
    check("rstmid_tvalue", tv_o, 64'd0);
    check("rstmid_cycle1", cyc_o[1], 15'd0);
    check("rstmid_rep1", rep_o[1], 16'hFFFF);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstmid_ready_after", bus.req_ready, 1'b1);
    v = '{1'b0, 1'b0, 1'b0, 1'b1, 15'd88, 16'd2, 1'b1, MSys, 64'd5, 2'd0, 1'b1};
    run_vec(v, "after_rst");

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
